// File: rtl/matmul_8x8_c_writeback.sv
// Result-tile writeback: buffers two-row result beats from the systolic array and
// serializes them into a single-port output BRAM, row_0 words first, then row_1.
module matmul_8x8_c_writeback #(
  parameter int DWIDTH          = 8,
  parameter int BB_MAT_MUL_SIZE = 4,
  parameter int AWIDTH          = 7,
  parameter int NUM_BEATS       = 8,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start_wb,
  input  logic [AWIDTH-1:0]                 c_addr_base,
  input  logic                              c_valid,
  input  logic [BB_MAT_MUL_SIZE*DWIDTH-1:0] c_data_row_0,
  input  logic [BB_MAT_MUL_SIZE*DWIDTH-1:0] c_data_row_1,
  output logic                              c_ready,
  output logic                              c_wr_en,
  output logic [AWIDTH-1:0]                 c_addr,
  output logic [BB_MAT_MUL_SIZE*DWIDTH-1:0] c_data_out,
  output logic                              busy,
  output logic                              done_wb
);

  localparam int WORD_W = BB_MAT_MUL_SIZE * DWIDTH;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(NUM_BEATS + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state_reg, state_next;
  logic [AWIDTH-1:0]   base_reg;
  logic [CNT_W-1:0]    in_cnt_reg, out_cnt_reg;
  logic                phase_reg;
  logic [2*WORD_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]      count_reg;
  logic                c_wr_en_reg;
  logic [AWIDTH-1:0]   c_addr_reg;
  logic [WORD_W-1:0]   c_data_out_reg;

  logic                fifo_full, fifo_empty, push, issue, pop;
  logic [2*WORD_W-1:0] head;

  assign fifo_full  = (count_reg == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty = (count_reg == '0);
  assign push       = c_valid && c_ready;
  assign issue      = (state_reg == S_RUN) && !fifo_empty;
  assign pop        = issue && phase_reg;
  assign head       = fifo_mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  // The last pop leaves out_cnt at NUM_BEATS while its row_1 write is on the bus.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start_wb) state_next = S_RUN;
      S_RUN:   if (out_cnt_reg == CNT_W'(NUM_BEATS)) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    c_ready = (state_reg == S_RUN) && !fifo_full && (in_cnt_reg < CNT_W'(NUM_BEATS));
    busy    = (state_reg == S_RUN);
    done_wb = (state_reg == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= {c_data_row_1, c_data_row_0};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_reg    <= '0;
      in_cnt_reg  <= '0;
      out_cnt_reg <= '0;
      phase_reg   <= 1'b0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
    end else if (state_reg == S_IDLE && start_wb) begin
      base_reg    <= c_addr_base;
      in_cnt_reg  <= '0;
      out_cnt_reg <= '0;
      phase_reg   <= 1'b0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        in_cnt_reg <= in_cnt_reg + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr_reg  <= rd_ptr_reg + PTR_W'(1);
        out_cnt_reg <= out_cnt_reg + CNT_W'(1);
      end
      if (push && !pop)      count_reg <= count_reg + (PTR_W+1)'(1);
      else if (!push && pop) count_reg <= count_reg - (PTR_W+1)'(1);
      if (issue) phase_reg <= ~phase_reg;
    end
  end

  // Address arithmetic is deliberately modulo 2^AWIDTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      c_wr_en_reg    <= 1'b0;
      c_addr_reg     <= '0;
      c_data_out_reg <= '0;
    end else begin
      c_wr_en_reg <= issue;
      if (issue) begin
        if (!phase_reg) begin
          c_data_out_reg <= head[WORD_W-1:0];
          c_addr_reg     <= base_reg + AWIDTH'(out_cnt_reg);
        end else begin
          c_data_out_reg <= head[2*WORD_W-1:WORD_W];
          c_addr_reg     <= base_reg + AWIDTH'(NUM_BEATS) + AWIDTH'(out_cnt_reg);
        end
      end
    end
  end

  assign c_wr_en    = c_wr_en_reg;
  assign c_addr     = c_addr_reg;
  assign c_data_out = c_data_out_reg;

endmodule

// File: doc/matmul_8x8_c_writeback.md
Name: matmul_8x8_c_writeback

Overview:
- Downstream of the 8x8 systolic matmul.
- Consumes the two 4-element result streams (c_data_row_0 and c_data_row_1, one word each per beat) and serializes them into a single-write-port output BRAM.
- Buffers up to FIFO_DEPTH beats. Back-pressures the producer with c_ready.
- Raises done_wb once the whole 8x8 result tile has been written.

Parameters:
- DWIDTH, 8, element width in bits.
- BB_MAT_MUL_SIZE, 4, elements per row word; word width = BB_MAT_MUL_SIZE*DWIDTH = 32.
- AWIDTH, 7, output BRAM address width.
- NUM_BEATS, 8, beats per result tile; each beat carries one word per block row.
- FIFO_DEPTH, 4, buffered beats; must be a power of 2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start_wb  in  1  one-cycle pulse; arms writeback of one tile.
- c_addr_base  in  AWIDTH  tile base address; sampled on start_wb.
- c_valid  in  1  producer beat valid.
- c_data_row_0  in  32  upper block-row result word.
- c_data_row_1  in  32  lower block-row result word.
- c_ready  out  1  beat is accepted when c_valid && c_ready.
- c_wr_en  out  1  BRAM write enable.
- c_addr  out  AWIDTH  BRAM write address.
- c_data_out  out  32  BRAM write data.
- busy  out  1  high in RUN.
- done_wb  out  1  one-cycle pulse at tile completion.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset (any state, including mid-tile):
  - state=IDLE; FIFO emptied.
  - in_cnt, out_cnt and phase cleared.
  - c_ready, c_wr_en, busy and done_wb = 0; c_addr = 0; c_data_out = 0.
  - Partially written data is abandoned.
- States: IDLE, RUN, DONE.
  - IDLE: c_ready=0. start_wb latches c_addr_base into base, clears counters, and moves to RUN. In any other state start_wb is ignored.
  - RUN: busy=1. Moves to DONE in the cycle after the final write.
  - DONE: done_wb=1 for exactly one cycle, then IDLE.
- Input side:
  - c_ready = (state==RUN) && !fifo_full && (in_cnt < NUM_BEATS).
  - c_ready is computed from registered state only. It has no combinational path from c_valid.
  - On acceptance, the 64-bit entry {row_1,row_0} is pushed and in_cnt increments.
  - Beats offered after NUM_BEATS have been accepted are not taken; c_ready stays 0.
- Output side, registered:
  - When the FIFO is non-empty in RUN, the next cycle drives c_wr_en=1.
  - phase=0: c_data_out = head row_0, c_addr = base + out_cnt.
  - phase=1: c_data_out = head row_1, c_addr = base + NUM_BEATS + out_cnt. The head is popped, out_cnt increments, and phase returns to 0.
  - phase toggles on every write.
  - c_wr_en=0 whenever the FIFO is empty; c_addr and c_data_out then hold their last values.
- Addresses are computed modulo 2^AWIDTH and wrap silently, e.g. base 124 + 5 = 1.
- Latency: a beat accepted at edge t produces its row_0 write in the cycle after t and its row_1 write in the cycle after that, provided the FIFO was empty.
- Throughput: 1 write per cycle, so 1 beat per 2 cycles sustained. A producer running faster fills the FIFO, and c_ready then drops.
- Simultaneous push and pop in the same cycle are both performed; the occupancy count is unchanged. Full status is evaluated before the push, so a push into a full FIFO never occurs.
- Completion: the write with out_cnt==NUM_BEATS-1 and phase=1 is the last one. DONE follows on the next edge, and done_wb is high the cycle after the last c_wr_en.
- Total writes per tile = 2*NUM_BEATS = 16.

Test Plan:
- Reset, then idle: all outputs 0 and c_ready=0 before start. With c_valid=1 and no start, nothing is accepted and c_wr_en stays 0.
- Nominal tile, base=0x10, producer valid every other cycle, beat k row_0=0xA0+k and row_1=0xB0+k:
  - row_0 words written to 0x10..0x17 with data 0xA0..0xA7.
  - row_1 words written to 0x18..0x1F with data 0xB0..0xB7.
  - Exactly 16 writes; done_wb pulses once, then busy=0.
- Back-to-back c_valid for 8 cycles: c_ready drops after 4 outstanding beats and recovers as the FIFO drains. All 16 writes are correct and in order, with no gaps in c_wr_en once it starts.
- Address wrap, base=124: row_0 addresses are 124,125,126,127,0,1,2,3 and row_1 addresses are 4..11.
- Reset asserted after 5 writes: next cycle all outputs are 0, state is IDLE and the FIFO is empty. A new start with base=0 writes addresses 0..15 cleanly.
- start_wb pulsed during RUN and c_valid held after 8 beats: start is ignored and base is unchanged. A 9th beat is never accepted, and done_wb fires after exactly 16 writes.
